// File: rtl/counter_pkg.sv
// counter_pkg: state encoding and parameter checks shared by the up/down counters
package counter_pkg;
  typedef enum logic {RUN = 1'b0, EXPIRED = 1'b1} cnt_state_t;
  function automatic bit max_fits(longint unsigned max_v, int unsigned width);
    return width >= 63 || max_v <= (64'd1 << width) - 64'd1;
  endfunction
endpackage

// File: rtl/generic_down_counter.sv
// generic_down_counter: loadable down-counter/timer, periodic or one-shot; DOWN_COUNTER_LOOKAHEAD_EN adds TC_LOOKAHEAD
module generic_down_counter
  import counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX = 9
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic                     LOAD,
  input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE,
  input  logic                     AUTO_RELOAD,
  output logic                     TRIG_OUT,
  output logic [COUNTER_WIDTH-1:0] COUNT,
  output logic                     RUNNING,
  output logic                     DONE
`ifdef DOWN_COUNTER_LOOKAHEAD_EN
  ,
  output logic                     TC_LOOKAHEAD
`endif
);
  if (!max_fits(COUNTER_MAX, COUNTER_WIDTH)) begin : g_bad_max
    $error("COUNTER_MAX does not fit in COUNTER_WIDTH bits");
  end
  cnt_state_t state, state_n;
  logic [COUNTER_WIDTH-1:0] reload, reload_n, count_n;
  logic trig_n, step, tc;
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= RUN;
      COUNT <= COUNTER_WIDTH'(COUNTER_MAX);
      reload <= COUNTER_WIDTH'(COUNTER_MAX);
      TRIG_OUT <= 1'b0;
    end else begin
      state <= state_n;
      COUNT <= count_n;
      reload <= reload_n;
      TRIG_OUT <= trig_n;
    end
  end
  always_comb begin
    step = !LOAD && state == RUN && ENABLE;
    tc = step && COUNT == '0;
    state_n = LOAD ? RUN : (tc && !AUTO_RELOAD) ? EXPIRED : state;
    reload_n = LOAD ? LOAD_VALUE : reload;
    count_n = LOAD ? LOAD_VALUE : !step ? COUNT : tc ? (AUTO_RELOAD ? reload : COUNT) : COUNT - COUNTER_WIDTH'(1);
    trig_n = tc;
  end
  assign RUNNING = state == RUN;
  assign DONE = state == EXPIRED;
`ifdef DOWN_COUNTER_LOOKAHEAD_EN
  assign TC_LOOKAHEAD = RUNNING && COUNT == '0 && !LOAD;
`endif
endmodule

// File: tb/tb_generic_down_counter.sv
// tb_generic_down_counter: scoreboard bench with a behavioural timer model and random stimulus
module tb_generic_down_counter;
  localparam int W = 4;
  localparam int MAX = 9;
  typedef struct {
    logic [W-1:0] c;
    logic t, r, d;
  } exp_t;
  logic CLK = 0, RESET = 0, ENABLE = 0, LOAD = 0, AUTO_RELOAD = 0;
  logic [W-1:0] LOAD_VALUE = '0, COUNT;
  logic TRIG_OUT, RUNNING, DONE;
`ifdef DOWN_COUNTER_LOOKAHEAD_EN
  logic TC_LOOKAHEAD;
`endif
  int checks = 0, failures = 0;
  exp_t q[$];
  int m_cnt, m_rel;
  bit m_exp, m_trig;
  generic_down_counter #(.COUNTER_WIDTH(W), .COUNTER_MAX(MAX)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE),
    .AUTO_RELOAD(AUTO_RELOAD), .TRIG_OUT(TRIG_OUT), .COUNT(COUNT), .RUNNING(RUNNING),
    .DONE(DONE)
`ifdef DOWN_COUNTER_LOOKAHEAD_EN
    , .TC_LOOKAHEAD(TC_LOOKAHEAD)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask
  task automatic step(input bit rst_n, input bit en, input bit ld, input int lv, input bit ar);
    exp_t e;
    @(negedge CLK);
    RESET = rst_n; ENABLE = en; LOAD = ld; LOAD_VALUE = W'(lv); AUTO_RELOAD = ar;
`ifdef DOWN_COUNTER_LOOKAHEAD_EN
    #1 chk("tc_lookahead", int'(TC_LOOKAHEAD), int'(!m_exp && m_cnt == 0 && !ld));
`endif
    if (!rst_n) begin
      m_cnt = MAX; m_rel = MAX; m_exp = 0; m_trig = 0;
    end else if (ld) begin
      m_cnt = lv; m_rel = lv; m_exp = 0; m_trig = 0;
    end else if (!m_exp && en && m_cnt == 0) begin
      m_trig = 1;
      if (ar) m_cnt = m_rel;
      else m_exp = 1;
    end else begin
      m_trig = 0;
      if (!m_exp && en) m_cnt = m_cnt - 1;
    end
    e.c = W'(m_cnt); e.t = m_trig; e.r = !m_exp; e.d = m_exp;
    q.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("count", int'(COUNT), int'(e.c));
        chk("trig_out", int'(TRIG_OUT), int'(e.t));
        chk("running", int'(RUNNING), int'(e.r));
        chk("done", int'(DONE), int'(e.d));
      end
    end
  end
  initial begin : stim
    int n;
    m_cnt = MAX; m_rel = MAX; m_exp = 0; m_trig = 0;
    repeat (2) step(0, 0, 0, 0, 1);
    repeat (12) step(1, 1, 0, 0, 1);
    step(1, 0, 1, 3, 0);
    repeat (24) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 2, 0);
    repeat (2) step(1, 1, 0, 0, 1);
    step(1, 1, 1, 5, 1);
    repeat (2) step(1, 1, 0, 0, 1);
    step(1, 0, 1, 2, 1);
    step(1, 1, 0, 0, 1); step(1, 0, 0, 0, 1); step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1); step(1, 1, 0, 0, 1); step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    repeat (6) step(1, 1, 0, 0, 1);
    step(1, 0, 1, 15, 1);
    repeat (34) step(1, 1, 0, 0, 1);
    step(1, 0, 1, 1, 1);
    step(1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0, 1);
    repeat (400) step($urandom_range(0, 39) != 0, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0);
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge CLK);
      n++;
    end
    #3;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected responses left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/generic_down_counter.md
Name: generic_down_counter

Overview:
Parameterised loadable down-counter/timer; the count-down counterpart of the team's up-counter.
- Counts from a reload value to 0 on each enabled cycle.
- Emits a registered one-cycle terminal-count pulse on TRIG_OUT.
- Either auto-reloads (periodic divider, cascadable stage) or stops in an expired state (one-shot timer, e.g. timeouts and watchdogs in the mouse interface path).

Parameters:
- COUNTER_WIDTH, 4, width of COUNT, LOAD_VALUE and the internal reload register.
- COUNTER_MAX, 9, reload value after reset. Must satisfy COUNTER_MAX <= 2**COUNTER_WIDTH-1; a violation is an elaboration-time error.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-low reset (0 = reset, sampled on CLK rising edge).
- ENABLE  input  1  count enable / borrow-in from the previous stage.
- LOAD  input  1  one-cycle strobe; loads LOAD_VALUE into COUNT and the reload register.
- LOAD_VALUE  input  COUNTER_WIDTH  value captured when LOAD=1.
- AUTO_RELOAD  input  1  1 = periodic mode; 0 = one-shot mode.
- TRIG_OUT  output  1  registered terminal-count pulse, one cycle wide.
- COUNT  output  COUNTER_WIDTH  current count (registered).
- RUNNING  output  1  1 while state = RUN.
- DONE  output  1  1 while state = EXPIRED.

Behaviour:
- Single clock domain: one clock, CLK; reset is synchronous and active-low (RESET).
- Reset (RESET=0 at the edge): COUNT=COUNTER_MAX, reload_reg=COUNTER_MAX, state=RUN, TRIG_OUT=0. So RUNNING=1 and DONE=0 in the first cycle after reset.
- States: RUN and EXPIRED. RUNNING and DONE are decoded directly from the state register (no extra latency).
- Priority at each edge: RESET > LOAD > ENABLE.
- LOAD=1 (any state):
  - COUNT<=LOAD_VALUE, reload_reg<=LOAD_VALUE, state<=RUN, TRIG_OUT<=0.
  - ENABLE is ignored in that cycle, so no decrement and no pulse.
- RUN, ENABLE=1, COUNT!=0: COUNT<=COUNT-1; TRIG_OUT<=0.
- RUN, ENABLE=1, COUNT==0: TRIG_OUT<=1.
  - AUTO_RELOAD=1: COUNT<=reload_reg; stay in RUN.
  - AUTO_RELOAD=0: COUNT stays 0; state<=EXPIRED.
- RUN, ENABLE=0: COUNT holds; TRIG_OUT<=0.
- EXPIRED: COUNT holds 0; ENABLE is ignored; TRIG_OUT<=0. Only LOAD or RESET leaves this state.
- Latency: TRIG_OUT is high for exactly the one cycle after the enabled edge at which COUNT was 0.
  - Auto-reload period = reload_reg+1 enabled cycles.
  - reload_reg=0 in auto-reload mode gives TRIG_OUT=1 on every cycle following an enabled cycle.
- AUTO_RELOAD is sampled only at the terminal-count edge; changing it mid-count has no other effect.
- Arithmetic: unsigned, modulo 2**COUNTER_WIDTH. Underflow below 0 never occurs because the count reloads or halts at 0.
- Reset mid-count: the count restarts at COUNTER_MAX, and any TRIG_OUT due on the next cycle is suppressed.
- Cascading with TRIG_OUT -> ENABLE adds one cycle of skew per stage.

Optional Feature:
- Macro: DOWN_COUNTER_LOOKAHEAD_EN.
- Defined: adds output TC_LOOKAHEAD (1 bit, combinational) = RUNNING && COUNT==0 && !LOAD. A following stage can then use ENABLE_next = ENABLE && TC_LOOKAHEAD for zero-skew cascading. TRIG_OUT is unchanged.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package counter_pkg holds:
  - the state encoding (RUN=1'b0, EXPIRED=1'b1) as a typedef / localparams;
  - a width-check helper, also reused by the up-counter.
- No sub-module: the terminal-count detect and reload mux are a few lines and stay inline.

Test Plan:
- Reset default: RESET=0 for 2 cycles, release, ENABLE=1, AUTO_RELOAD=1 -> COUNT sequence 9,8,...,0,9. TRIG_OUT=1 exactly once, in the cycle COUNT first shows 9 again. Period is 10 cycles.
- One-shot: LOAD=1, LOAD_VALUE=3, then ENABLE=1, AUTO_RELOAD=0 -> COUNT 3,2,1,0. TRIG_OUT one pulse, then DONE=1 and RUNNING=0. COUNT holds 0 for 20 further enabled cycles with no further pulses.
- Load priority: LOAD=1 with ENABLE=1 and COUNT=0 in RUN, LOAD_VALUE=5 -> COUNT=5 next cycle, TRIG_OUT stays 0. Also LOAD in EXPIRED -> RUNNING=1.
- Gated enable: ENABLE toggled 1,0,1,0 from COUNT=2 -> COUNT 2,1,1,0,0. TRIG_OUT pulses only after the enabled edge at COUNT=0.
- Reload 0 and boundary: LOAD_VALUE=0, AUTO_RELOAD=1, ENABLE=1 -> TRIG_OUT=1 every cycle, COUNT stays 0. LOAD_VALUE=15 -> 16-cycle period.
- Reset mid-operation: RESET=0 at the edge where COUNT=0 and ENABLE=1 -> next cycle COUNT=9, TRIG_OUT=0, RUNNING=1.
